// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C SCL generator: state encoding and default widths.
package i2c_pkg;

  localparam int unsigned PRESCALE_W_DEF = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOW_A  = 3'd1;
  localparam logic [2:0] ST_LOW_B  = 3'd2;
  localparam logic [2:0] ST_HIGH_A = 3'd3;
  localparam logic [2:0] ST_HIGH_B = 3'd4;

  function automatic logic drives_low(input logic [2:0] st);
    return (st == ST_LOW_A) || (st == ST_LOW_B);
  endfunction

endpackage

// File: rtl/i2c_scl_gen_timer.sv
// Load/enable up-counter used as the SCL phase timer; reset and load are synchronous.
module i2c_scl_gen_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= data_in;
    end else if (enable) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/i2c_scl_gen.sv
// I2C master SCL generator: four equal phases of prescale+1 cycles, phase ticks,
// and clock-stretch detection while SCL is released.
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  asyn_rst,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  scl_in,
  output logic                  scl_oe,
  output logic                  fall_tick,
  output logic                  change_tick,
  output logic                  rise_tick,
  output logic                  sample_tick,
  output logic                  stretching,
  output logic                  busy
);

  logic [2:0]            state_q, state_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic [PRESCALE_W-1:0] count;
  logic [PRESCALE_W-1:0] load_val;
  logic                  cnt_en, phase_done, phase_load, cnt_clear;
  logic                  rise_seen_q, rise_seen_d;
  logic                  scl_oe_q, fall_q, change_q, sample_q, busy_q;

  assign load_val = '0;

  // HIGH_A only counts once the bus has actually gone high.
  always_comb begin
    cnt_en = 1'b0;
    case (state_q)
      ST_LOW_A, ST_LOW_B, ST_HIGH_B: cnt_en = 1'b1;
      ST_HIGH_A:                     cnt_en = scl_in;
      default:                       cnt_en = 1'b0;
    endcase
  end

  assign phase_done = cnt_en && (count == p_q);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_LOW_A;
          p_d     = prescale;
        end
      end
      ST_LOW_A:  if (phase_done) state_d = ST_LOW_B;
      ST_LOW_B:  if (phase_done) state_d = ST_HIGH_A;
      ST_HIGH_A: if (phase_done) state_d = ST_HIGH_B;
      ST_HIGH_B: begin
        if (phase_done) begin
          if (enable) begin
            state_d = ST_LOW_A;
            p_d     = prescale;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign phase_load = (state_d != state_q);
  // Holding the timer cleared while stretched keeps HIGH_A at a full p_q+1 after release.
  assign cnt_clear  = asyn_rst || phase_load || ((state_q == ST_HIGH_A) && !scl_in);

  i2c_scl_gen_timer #(
    .WIDTH (PRESCALE_W)
  ) u_phase_timer (
    .clk     (clk),
    .rst     (cnt_clear),
    .load    (phase_load),
    .data_in (load_val),
    .enable  (cnt_en),
    .count   (count)
  );

  assign rise_seen_d = (state_q == ST_HIGH_A) && (rise_seen_q || scl_in);

  always_ff @(posedge clk) begin
    if (asyn_rst) begin
      state_q     <= ST_IDLE;
      p_q         <= '0;
      rise_seen_q <= 1'b0;
      scl_oe_q    <= 1'b0;
      fall_q      <= 1'b0;
      change_q    <= 1'b0;
      sample_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      rise_seen_q <= rise_seen_d;
      scl_oe_q    <= drives_low(state_d);
      fall_q      <= (state_d == ST_LOW_A) && (state_q != ST_LOW_A);
      change_q    <= (state_d == ST_LOW_B) && (state_q == ST_LOW_A);
      sample_q    <= (state_d == ST_HIGH_B) && (state_q == ST_HIGH_A);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign scl_oe      = scl_oe_q;
  assign fall_tick   = fall_q;
  assign change_tick = change_q;
  assign sample_tick = sample_q;
  assign busy        = busy_q;

  // The released line is only observable in the cycle it is seen, so these two
  // follow the synchronized scl_in directly rather than a cycle later.
  assign rise_tick  = (state_q == ST_HIGH_A) && scl_in && !rise_seen_q;
  assign stretching = (state_q == ST_HIGH_A) && !scl_in;

endmodule
